rr_arbiter_8: RTL and testbench
===============================

// Module: rr_arbiter_8
// PURPOSE
//  - Round-robin arbiter sharing one resource among 8 requesters; grant is a registered 3-bit index, one-hot decoded to gnt[7:0].
//  - Sits in front of any 8-way shared resource (bus, display digit, memory port); en gates new grants like a decoder enable.
//  - Grant is held until the owner drops its request; one idle cycle always separates successive grants.
// PARAMETERS
//  - MAX_HOLD  16  max cycles a grant may be held before forced revoke (used only with RR_ARB_TIMEOUT_EN); legal 2..2**CNT_W-1
//  - CNT_W     5   width of hold counter
// PORTS
//  - clk        in   1  clock, all state updates on rising edge
//  - rst        in   1  synchronous reset, active-high
//  - en         in   1  1 = new grants may be issued; 0 = no new grant, current grant continues until release
//  - req        in   8  request per requester, level, held high until done
//  - gnt        out  8  one-hot grant, all-zero when none
//  - gnt_idx    out  3  index of current owner; holds last owner when gnt_valid=0
//  - gnt_valid  out  1  1 while any grant is active (== |gnt)
//  - timeout    out  1  1-cycle pulse on forced revoke; constant 0 without RR_ARB_TIMEOUT_EN
// BEHAVIOUR
//  - Reset: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0 (req[0] highest priority), hold count=0, state IDLE.
//  - Reset mid-grant: everything returns to reset values at that edge; no timeout pulse.
//  - States: IDLE, GRANT. All outputs registered.
//  - IDLE: if en=1 and |req: winner = first set bit scanning ptr, ptr+1, ... ptr+7 (mod 8); next edge -> GRANT,
//    gnt_idx=winner, gnt=onehot(winner), gnt_valid=1. Latency: req sampled at edge N -> gnt high after edge N.
//    If en=0 or req==0: stay IDLE, outputs unchanged (gnt=0).
//  - GRANT: stay while req[gnt_idx]=1 (en and other reqs ignored). When req[gnt_idx]=0 at an edge -> IDLE,
//    gnt=0, gnt_valid=0, ptr=gnt_idx+1 (3-bit wrap: 7 -> 0). Minimum one cycle with gnt=0 between grants.
//  - Requests from other requesters changing during GRANT have no effect until next IDLE evaluation.
//  - Single requester repeatedly requesting is re-granted after each one-cycle gap (no starvation of self).
//  - Fairness: a continuously-requesting requester waits at most 7 other grants.
// CONFIGURATION
//  - Macro RR_ARB_TIMEOUT_EN defined: hold counter clears on entry to GRANT, increments each GRANT cycle.
//    Edge at which count==MAX_HOLD-1 and req[gnt_idx] still 1: -> IDLE, gnt=0, ptr=gnt_idx+1, timeout=1 for one cycle.
//    Release and limit on the same edge: normal release, timeout=0. Revoked requester may be re-granted
//    only via normal round-robin order (lowest priority).
//  - Macro undefined: no counter, grant held indefinitely, timeout tied 0, MAX_HOLD/CNT_W unused.
// STRUCTURE
//  - Shared package arb_pkg: NUM_REQ=8, IDX_W=3, state encoding ST_IDLE=1'b0 / ST_GRANT=1'b1.
//  - One sub-module: arb_idx_decode (combinational 3->8 one-hot decode with enable) converts next gnt_idx to gnt;
//    top holds FSM, ptr, priority scan, hold counter.
// TESTING
//  - Reset: rst=1 with req=8'hFF for 2 cycles -> gnt=0, gnt_valid=0, gnt_idx=0, timeout=0.
//  - Rotation: req=8'hFF held, each owner drops req 3 cycles after grant then re-raises -> grant order 0,1,...,7,0;
//    exactly one gnt=0 cycle between grants.
//  - Wrap/skip: ptr=6, req=8'b0000_0101 -> gnt=8'h01 (idx 0); after release ptr=1, next winner idx 2.
//  - Enable: en=0, req=8'h10 for 5 cycles -> gnt stays 0; en=1 -> gnt=8'h10 after one edge; en=0 mid-grant -> grant kept.
//  - Reset mid-grant: gnt=8'h08, assert rst one cycle -> gnt=0, ptr=0; req=8'h09 after -> gnt=8'h01.
//  - Timeout (macro on, MAX_HOLD=4): req=8'h02 held -> gnt=8'h02 for 4 cycles, then gnt=0 with timeout=1 for 1 cycle,
//    regranted next edge; with macro off the same stimulus holds gnt=8'h02 indefinitely, timeout=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM encoding
// and the rotating-priority pick helper.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Scan from the highest offset down so the lowest offset from ptr is the
    // last assignment and therefore wins; the index sum wraps modulo 8.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p.found = 1'b0;
        p.idx   = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/arb_idx_decode.sv
// Combinational 3->8 one-hot decoder with enable; all-zero output when disabled.
module arb_idx_decode
    import arb_pkg::*;
(
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    // One-hot decode of the index, gated by the enable
    always_comb begin
        onehot = 8'h00;
        if (en) begin
            case (idx)
                3'd0:    onehot = 8'h01;
                3'd1:    onehot = 8'h02;
                3'd2:    onehot = 8'h04;
                3'd3:    onehot = 8'h08;
                3'd4:    onehot = 8'h10;
                3'd5:    onehot = 8'h20;
                3'd6:    onehot = 8'h40;
                3'd7:    onehot = 8'h80;
                default: onehot = 8'h00;
            endcase
        end else begin
            onehot = 8'h00;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with registered one-hot grant and a mandatory idle
// cycle between grants. Define RR_ARB_TIMEOUT_EN to enable forced revoke after MAX_HOLD cycles.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    // Empty block: elaboration only diverges here when the hold limit cannot fit the counter.
    if (MAX_HOLD < 2 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_max_hold_out_of_range
    end

    state_e               state_r;
    state_e               state_nxt_s;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     ptr_nxt_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_nxt_s;
    logic [NUM_REQ-1:0]   gnt_r;
    logic [NUM_REQ-1:0]   gnt_nxt_s;
    logic                 gnt_valid_r;
    logic                 timeout_r;
    logic                 timeout_nxt_s;
    pick_t                pick_s;
    logic                 grant_s;
    logic                 release_s;
    logic                 revoke_s;

    assign pick_s    = rr_pick(req, ptr_r);
    assign grant_s   = (state_r == ST_IDLE) && en && pick_s.found;
    assign release_s = (state_r == ST_GRANT) && !req[idx_r];

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt_r;

    assign revoke_s = (state_r == ST_GRANT) && req[idx_r] && (hold_cnt_r == HOLD_LIMIT);

    // Hold counter: cleared on entry to GRANT, counts every GRANT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_s) begin
            hold_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_GRANT) begin
            hold_cnt_r <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end
`else
    assign revoke_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: grant from IDLE, leave GRANT on release or revoke
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s || revoke_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs (pre-register): owner index, rotating pointer, revoke pulse
    always_comb begin
        idx_nxt_s     = idx_r;
        ptr_nxt_s     = ptr_r;
        timeout_nxt_s = revoke_s;
        if (grant_s) begin
            idx_nxt_s = pick_s.idx;
        end else begin
            idx_nxt_s = idx_r;
        end
        if (release_s || revoke_s) begin
            ptr_nxt_s = idx_r + 3'd1;
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    arb_idx_decode u_idx_decode (
        .en     (state_nxt_s == ST_GRANT),
        .idx    (idx_nxt_s),
        .onehot (gnt_nxt_s)
    );

    // Registered outputs and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= 3'd0;
            idx_r       <= 3'd0;
            gnt_r       <= 8'h00;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            ptr_r       <= ptr_nxt_s;
            idx_r       <= idx_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_valid_r <= (state_nxt_s == ST_GRANT);
            timeout_r   <= timeout_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = idx_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8; expectations hand-derived,
// timeout section follows RR_ARB_TIMEOUT_EN with MAX_HOLD=4.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp;
    int n_err;

    rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [7:0] exp_gnt,
                               input logic [2:0] exp_idx, input logic exp_valid);
        check_eq({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check_eq({tag, ".idx"}, 32'(gnt_idx), 32'(exp_idx));
        check_eq({tag, ".valid"}, 32'(gnt_valid), 32'(exp_valid));
    endtask

    initial begin
        logic [7:0] oh;
        logic [2:0] nxt;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        en  = 1'b1;
        req = 8'hFF;

        // Reset with all requests high
        tick();
        tick();
        check_grant("reset", 8'h00, 3'd0, 1'b0);
        check_eq("reset.timeout", 32'(timeout), 32'd0);
        rst = 1'b0;

        // Rotation 0..7,0 with one idle gap between grants
        tick();
        check_grant("rot_first", 8'h01, 3'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            oh  = 8'h01 << k;
            nxt = 3'(k + 1);
            tick();
            tick();
            check_eq("rot_hold", 32'(gnt), 32'(oh));
            req[k] = 1'b0;
            tick();
            check_grant("rot_gap", 8'h00, 3'(k), 1'b0);
            req[k] = 1'b1;
            tick();
            check_grant("rot_next", 8'h01 << nxt, nxt, 1'b1);
        end
        req = 8'h00;
        tick();
        check_grant("rot_end", 8'h00, 3'd0, 1'b0);

        // Wrap/skip: bring ptr to 6 via requester 5, then 0 and 2 request
        req = 8'h20;
        tick();
        check_grant("wrap_setup", 8'h20, 3'd5, 1'b1);
        req = 8'h00;
        tick();
        req = 8'b0000_0101;
        tick();
        check_grant("wrap_win0", 8'h01, 3'd0, 1'b1);
        req = 8'b0000_0100;
        tick();
        check_eq("wrap_gap", 32'(gnt), 32'h00);
        tick();
        check_grant("wrap_win2", 8'h04, 3'd2, 1'b1);
        req = 8'h00;
        tick();

        // Enable gating: no grant while en=0, grant kept when en drops mid-grant
        en  = 1'b0;
        req = 8'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("en_off", 32'(gnt), 32'h00);
        end
        en = 1'b1;
        tick();
        check_grant("en_on", 8'h10, 3'd4, 1'b1);
        en = 1'b0;
        tick();
        tick();
        check_grant("en_mid", 8'h10, 3'd4, 1'b1);
        req = 8'h00;
        tick();
        en = 1'b1;

        // Reset mid-grant restores ptr=0
        req = 8'h08;
        tick();
        check_grant("mid_pre", 8'h08, 3'd3, 1'b1);
        rst = 1'b1;
        tick();
        check_grant("mid_rst", 8'h00, 3'd0, 1'b0);
        check_eq("mid_rst.timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        req = 8'h09;
        tick();
        check_grant("mid_after", 8'h01, 3'd0, 1'b1);
        req = 8'h00;
        tick();

        // Hold limit behaviour with a single persistent requester
        req = 8'h02;
        tick();
        check_grant("to_grant", 8'h02, 3'd1, 1'b1);
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("to_held", 32'(gnt), 32'h02);
            check_eq("to_held.timeout", 32'(timeout), 32'd0);
        end
        tick();
        check_grant("to_revoke", 8'h00, 3'd1, 1'b0);
        check_eq("to_revoke.timeout", 32'(timeout), 32'd1);
        tick();
        check_grant("to_regrant", 8'h02, 3'd1, 1'b1);
        check_eq("to_regrant.timeout", 32'(timeout), 32'd0);
        tick();
        tick();
        tick();
        req = 8'h00;
        tick();
        check_grant("to_rel_at_limit", 8'h00, 3'd1, 1'b0);
        check_eq("to_rel_at_limit.timeout", 32'(timeout), 32'd0);
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("nto_held", 32'(gnt), 32'h02);
            check_eq("nto_timeout", 32'(timeout), 32'd0);
        end
        req = 8'h00;
        tick();
        check_grant("nto_release", 8'h00, 3'd1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
